// File: rtl/ga_pkg.sv
// Shared GA pipeline definitions: population defaults, LFSR constants and the
// selection FSM state type.
package ga_pkg;

  localparam int FIT_W_DEFAULT    = 16;
  localparam int POP_SIZE_DEFAULT = 64;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    LOAD,
    READY,
    TOUR,
    DONE
  } sel_state_t;

  // One right-shift Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with advance enable and seed load; a zero seed is replaced
// by the default seed so the register can never lock up.
module lfsr16
  import ga_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             seed_wr_i,
  input  logic [15:0]      seed_data_i,
  output logic [OUT_W-1:0] state_o
);

  logic [15:0] state_q, state_d;

  // A seed write overrides an advance in the same cycle.
  always_comb begin
    state_d = state_q;
    if (seed_wr_i) begin
      state_d = (seed_data_i == 16'h0000) ? LFSR_SEED_DEFAULT : seed_data_i;
    end else if (en_i) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= LFSR_SEED_DEFAULT;
    else       state_q <= state_d;
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/tournament_select.sv
// Buffers one generation of fitness scores and serves K-way tournament parent
// selections. Optional elite tracking: define TOURNAMENT_SELECT_ELITISM_EN.
module tournament_select
  import ga_pkg::*;
#(
  parameter int POP_SIZE = POP_SIZE_DEFAULT,
  parameter int FIT_W    = FIT_W_DEFAULT,
  parameter int TOUR_K   = 4,
  parameter int IDX_W    = $clog2(POP_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_gen,
  input  logic             seed_wr,
  input  logic [15:0]      seed_data,
  input  logic             fit_valid,
  output logic             fit_ready,
  input  logic [FIT_W-1:0] fit_data,
  output logic             pop_loaded,
  input  logic             sel_req,
  output logic             sel_busy,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_idx,
  output logic [FIT_W-1:0] sel_fit,
  output logic [IDX_W-1:0] best_idx,
  output logic [FIT_W-1:0] best_fit
);

  sel_state_t       state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]       draw_q, draw_d;
  logic [IDX_W-1:0] champ_idx_q, champ_idx_d;
  logic [FIT_W-1:0] champ_fit_q, champ_fit_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic [FIT_W-1:0] sel_fit_q, sel_fit_d;

  logic [FIT_W-1:0] mem [POP_SIZE];
  logic [IDX_W-1:0] cand;
  logic [FIT_W-1:0] cand_fit;
  logic             fit_hs;

  lfsr16 #(.OUT_W(IDX_W)) u_lfsr (
    .clk         (clk),
    .reset       (reset),
    .en_i        (state_q == TOUR),
    .seed_wr_i   (seed_wr),
    .seed_data_i (seed_data),
    .state_o     (cand)
  );

  assign cand_fit = mem[cand];
  assign fit_hs   = (state_q == LOAD) && fit_valid;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    draw_d      = draw_q;
    champ_idx_d = champ_idx_q;
    champ_fit_d = champ_fit_q;
    sel_idx_d   = sel_idx_q;
    sel_fit_d   = sel_fit_q;
    unique case (state_q)
      LOAD: begin
        if (fit_hs) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == IDX_W'(POP_SIZE - 1)) state_d = READY;
        end
      end
      READY: begin
        if (sel_req) begin
          state_d = TOUR;
          draw_d  = '0;
        end
      end
      TOUR: begin
        draw_d = draw_q + 1'b1;
        // Strict compare: on a tie the earlier draw stays champion.
        if (draw_q == 3'd0 || cand_fit > champ_fit_q) begin
          champ_idx_d = cand;
          champ_fit_d = cand_fit;
        end
        if (draw_q == 3'(TOUR_K - 1)) begin
          state_d   = DONE;
          sel_idx_d = champ_idx_d;
          sel_fit_d = champ_fit_d;
        end
      end
      DONE:    state_d = READY;
      default: state_d = LOAD;
    endcase
    if (new_gen) begin
      state_d  = LOAD;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      draw_q      <= '0;
      champ_idx_q <= '0;
      champ_fit_q <= '0;
      sel_idx_q   <= '0;
      sel_fit_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      draw_q      <= draw_d;
      champ_idx_q <= champ_idx_d;
      champ_fit_q <= champ_fit_d;
      sel_idx_q   <= sel_idx_d;
      sel_fit_q   <= sel_fit_d;
    end
  end

  // Buffer is never cleared; a new generation simply overwrites it.
  always_ff @(posedge clk) begin
    if (!reset && fit_hs && !new_gen) mem[wr_ptr_q] <= fit_data;
  end

  assign fit_ready  = (state_q == LOAD);
  assign pop_loaded = (state_q != LOAD);
  assign sel_busy   = (state_q == TOUR);
  assign sel_valid  = (state_q == DONE);
  assign sel_idx    = sel_idx_q;
  assign sel_fit    = sel_fit_q;

`ifdef TOURNAMENT_SELECT_ELITISM_EN
  logic [IDX_W-1:0] best_idx_q;
  logic [FIT_W-1:0] best_fit_q;

  always_ff @(posedge clk) begin
    if (reset || new_gen) begin
      best_idx_q <= '0;
      best_fit_q <= '0;
    end else if (fit_hs && fit_data > best_fit_q) begin
      best_idx_q <= wr_ptr_q;
      best_fit_q <= fit_data;
    end
  end

  assign best_idx = best_idx_q;
  assign best_fit = best_fit_q;
`else
  assign best_idx = '0;
  assign best_fit = '0;
`endif

endmodule

// File: tb/tb_tournament_select.sv
// Directed, table-driven bench for tournament_select (POP_SIZE=64, TOUR_K=4)
// with a reference LFSR/tournament model.
module tb_tournament_select;

  localparam int POP = 64;
  localparam int K   = 4;

  logic        clk = 1'b0;
  logic        reset, new_gen, seed_wr, fit_valid, sel_req;
  logic [15:0] seed_data, fit_data;
  logic        fit_ready, pop_loaded, sel_busy, sel_valid;
  logic [5:0]  sel_idx, best_idx;
  logic [15:0] sel_fit, best_fit;

  tournament_select dut (
    .clk        (clk),
    .reset      (reset),
    .new_gen    (new_gen),
    .seed_wr    (seed_wr),
    .seed_data  (seed_data),
    .fit_valid  (fit_valid),
    .fit_ready  (fit_ready),
    .fit_data   (fit_data),
    .pop_loaded (pop_loaded),
    .sel_req    (sel_req),
    .sel_busy   (sel_busy),
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .sel_fit    (sel_fit),
    .best_idx   (best_idx),
    .best_fit   (best_fit)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mdl_mem [POP];
  logic [15:0] mdl_lfsr;
  int          exp_best_idx, exp_best_fit;

  typedef struct {
    bit          seed_en;
    logic [15:0] seed;
    int          exp_idx;   // -1: take the value from the reference model
    int          exp_fit;
  } vec_t;
  vec_t vecs[5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] adv(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic model_tour(inout logic [15:0] l, output int idx, output int fit);
    for (int d = 0; d < K; d++) begin
      if (d == 0 || int'(mdl_mem[l[5:0]]) > fit) begin
        idx = int'(l[5:0]);
        fit = int'(mdl_mem[l[5:0]]);
      end
      l = adv(l);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mdl_lfsr = 16'hACE1;
  endtask

  // mode 0: fit=i, 1: all 0x100, 2: 1000-7i, 3: 7 except 900 at 10 and 40
  task automatic load_pop(input int mode);
    logic [15:0] v;
    exp_best_idx = 0;
    exp_best_fit = 0;
    for (int i = 0; i < POP; i++) begin
      case (mode)
        0:       v = 16'(i);
        1:       v = 16'h0100;
        2:       v = 16'(1000 - 7 * i);
        default: v = (i == 10 || i == 40) ? 16'd900 : 16'd7;
      endcase
      mdl_mem[i] = v;
      if (int'(v) > exp_best_fit) begin
        exp_best_fit = int'(v);
        exp_best_idx = i;
      end
      repeat ($urandom_range(0, 2)) tick();
      if (i == 32) chk("load_mid_pop_loaded", 32'(pop_loaded), 32'd0);
      fit_valid = 1'b1;
      fit_data  = v;
      tick();
      fit_valid = 1'b0;
    end
    chk("load_pop_loaded", 32'(pop_loaded), 32'd1);
    chk("load_fit_ready", 32'(fit_ready), 32'd0);
`ifndef TOURNAMENT_SELECT_ELITISM_EN
    exp_best_idx = 0;
    exp_best_fit = 0;
`endif
    chk("load_best_idx", 32'(best_idx), 32'(exp_best_idx));
    chk("load_best_fit", 32'(best_fit), 32'(exp_best_fit));
    $display("load mode=%0d done best_idx=%0d best_fit=%0d", mode, best_idx, best_fit);
  endtask

  task automatic do_select(input string name, input int exp_idx, input int exp_fit);
    int cyc;
    logic [5:0] held;
    sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    chk({name, "_busy"}, 32'(sel_busy), 32'd1);
    cyc = 1;
    while (!sel_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(K + 1));
    chk({name, "_idx"}, 32'(sel_idx), 32'(exp_idx));
    chk({name, "_fit"}, 32'(sel_fit), 32'(exp_fit));
    $display("select %s: lat=%0d idx=%0d fit=%0h", name, cyc, sel_idx, sel_fit);
    held = sel_idx;
    tick();
    chk({name, "_pulse"}, 32'(sel_valid), 32'd0);
    chk({name, "_hold"}, 32'(sel_idx), 32'(held));
  endtask

  initial begin
    int mi, mf, ei, ef, cyc;
    int seen;
    logic [15:0] l;

    reset = 1'b0; new_gen = 1'b0; seed_wr = 1'b0; seed_data = '0;
    fit_valid = 1'b0; fit_data = '0; sel_req = 1'b0;

    vecs[0] = '{1'b0, 16'h0000, 56, 56};   // draws from ACE1: 33,48,56,28
    vecs[1] = '{1'b1, 16'h1234, 52, 52};   // draws: 52,26,13,6
    vecs[2] = '{1'b1, 16'h0000, 56, 56};   // zero seed falls back to ACE1
    vecs[3] = '{1'b1, 16'hBEEF, -1, -1};
    vecs[4] = '{1'b0, 16'h0000, -1, -1};

    do_reset();
    chk("rst_fit_ready", 32'(fit_ready), 32'd1);
    chk("rst_pop_loaded", 32'(pop_loaded), 32'd0);
    chk("rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("rst_sel_busy", 32'(sel_busy), 32'd0);
    chk("rst_sel_idx", 32'(sel_idx), 32'd0);
    chk("rst_sel_fit", 32'(sel_fit), 32'd0);
    chk("rst_best", 32'({best_idx, best_fit}), 32'd0);

    // sel_req in LOAD must be ignored
    sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    seen = 0;
    repeat (7) begin
      tick();
      if (sel_valid || sel_busy) seen++;
    end
    chk("load_selreq_ignored", 32'(seen), 32'd0);
    chk("load_selreq_ready", 32'(fit_ready), 32'd1);

    load_pop(0);
    // beats after the buffer is full are ignored
    fit_valid = 1'b1;
    fit_data  = 16'hFFFF;
    repeat (3) tick();
    fit_valid = 1'b0;
    chk("post_load_ready", 32'(fit_ready), 32'd0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].seed_en) begin
        seed_wr   = 1'b1;
        seed_data = vecs[v].seed;
        tick();
        seed_wr = 1'b0;
        mdl_lfsr = (vecs[v].seed == 16'h0000) ? 16'hACE1 : vecs[v].seed;
      end
      model_tour(mdl_lfsr, mi, mf);
      ei = (vecs[v].exp_idx >= 0) ? vecs[v].exp_idx : mi;
      ef = (vecs[v].exp_fit >= 0) ? vecs[v].exp_fit : mf;
      do_select($sformatf("vec%0d", v), ei, ef);
    end

    // Seed write during a TOUR cycle wins over the advance
    l = mdl_lfsr;
    ei = int'(l[5:0]);
    ef = int'(mdl_mem[l[5:0]]);
    l = 16'h1234;
    for (int d = 1; d < K; d++) begin
      if (int'(mdl_mem[l[5:0]]) > ef) begin
        ei = int'(l[5:0]);
        ef = int'(mdl_mem[l[5:0]]);
      end
      l = adv(l);
    end
    mdl_lfsr = l;
    sel_req = 1'b1;
    tick();
    sel_req   = 1'b0;
    seed_wr   = 1'b1;
    seed_data = 16'h1234;
    tick();
    seed_wr = 1'b0;
    cyc = 2;
    while (!sel_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("seed_in_tour_latency", 32'(cyc), 32'(K + 1));
    chk("seed_in_tour_idx", 32'(sel_idx), 32'(ei));
    chk("seed_in_tour_fit", 32'(sel_fit), 32'(ef));
    $display("select seed_in_tour: idx=%0d fit=%0h", sel_idx, sel_fit);
    tick();

    // Ties: first draw wins
    new_gen = 1'b1;
    tick();
    new_gen = 1'b0;
    load_pop(1);
    ei = int'(mdl_lfsr[5:0]);
    model_tour(mdl_lfsr, mi, mf);
    do_select("ties", ei, 16'h0100);

    // Abort on the second TOUR cycle
    sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    tick();
    new_gen = 1'b1;
    tick();
    new_gen = 1'b0;
    mdl_lfsr = adv(adv(mdl_lfsr));
    chk("abort_fit_ready", 32'(fit_ready), 32'd1);
    chk("abort_pop_loaded", 32'(pop_loaded), 32'd0);
    chk("abort_busy", 32'(sel_busy), 32'd0);
    seen = 0;
    repeat (8) begin
      if (sel_valid) seen++;
      tick();
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    $display("abort: fit_ready=%0d pop_loaded=%0d", fit_ready, pop_loaded);
    load_pop(2);
    model_tour(mdl_lfsr, mi, mf);
    do_select("after_abort", mi, mf);

    // Elite tracking with a tie at 900
    new_gen = 1'b1;
    tick();
    new_gen = 1'b0;
    load_pop(3);
    model_tour(mdl_lfsr, mi, mf);
    do_select("elite_pop", mi, mf);

    // Reset mid-operation reseeds the LFSR
    do_reset();
    chk("rst2_fit_ready", 32'(fit_ready), 32'd1);
    chk("rst2_pop_loaded", 32'(pop_loaded), 32'd0);
    chk("rst2_sel_idx", 32'(sel_idx), 32'd0);
    load_pop(0);
    do_select("after_reset", 56, 56);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
